// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the timer interrupt controller.
// Holds the 2-bit FSM state encoding, the default vector base, the TIFR
// bit-name constants and a helper that turns a flag index into the word
// offset of its vector relative to the vector base.
package interrupt_controller_pkg;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PUSH_L = 2'd1;
    localparam logic [1:0] ST_PUSH_H = 2'd2;
    localparam logic [1:0] ST_VECTOR = 2'd3;

    // Word address of the vector serving TIFR bit 7.
    localparam logic [13:0] VEC_BASE_DEFAULT = 14'h008;

    // TIFR bit positions (combined timer0/timer1/timer2 flag register).
    typedef enum logic [2:0] {
        TOV0  = 3'd0,
        OCF0  = 3'd1,
        TOV1  = 3'd2,
        OCF1B = 3'd3,
        OCF1A = 3'd4,
        ICF1  = 3'd5,
        TOV2  = 3'd6,
        OCF2  = 3'd7
    } tifr_bit_e;

    // Vector offset 2*(7-idx); for a 3-bit index 7-idx is simply ~idx.
    function automatic logic [3:0] vec_offset(input logic [2:0] idx);
        return {~idx, 1'b0};
    endfunction

endpackage

// File: rtl/priority_encoder_8.sv
// Combinational 8-to-3 priority encoder; the highest set bit wins.
// Ports:
//   req   in  8  request vector
//   valid out 1  at least one request bit set
//   idx   out 3  index of the highest set bit (0 when valid is low)
module priority_encoder_8 (
    input  logic [7:0] req,
    output logic       valid,
    output logic [2:0] idx
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        valid = |req;
        idx   = 3'd0;
        // Ascending scan: a later (higher) set bit overrides earlier ones.
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Timer interrupt controller.
// At an instruction boundary with global interrupts enabled it picks the
// highest-priority pending, unmasked TIFR flag, stalls fetch, pushes the
// return address (low byte first, stack growing down), loads the vector into
// the PC, clears SREG.I and write-one-clears the serviced TIFR flag.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   tifr, timsk           pending flags and their enables (same layout)
//   sreg_i                SREG bit 7, global interrupt enable
//   instr_boundary        current instruction completes this cycle
//   program_counter       return address to push
//   sp                    current stack pointer
//   hold                  stall fetch / PC increment while servicing
//   PC_overwrite, PC_new  one-cycle PC load strobe and vector address
//   mem_we/addr/data      data-memory write port for the pushes
//   sp_we, sp_new         stack-pointer load strobe and value
//   clear_i               one-cycle pulse clearing SREG bit 7
//   tifr_clear            one-hot write-one-to-clear to TIFR
//   busy                  any state other than IDLE
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int              PC_W     = 14,
    parameter logic [PC_W-1:0] VEC_BASE = PC_W'(VEC_BASE_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [7:0]      tifr,
    input  logic [7:0]      timsk,
    input  logic            sreg_i,
    input  logic            instr_boundary,
    input  logic [PC_W-1:0] program_counter,
    input  logic [15:0]     sp,
    output logic            hold,
    output logic            PC_overwrite,
    output logic [PC_W-1:0] PC_new,
    output logic            mem_we,
    output logic [15:0]     mem_addr,
    output logic [7:0]      mem_data,
    output logic            sp_we,
    output logic [15:0]     sp_new,
    output logic            clear_i,
    output logic [7:0]      tifr_clear,
    output logic            busy
);

    logic [1:0]      state;
    logic            guard;
    logic [2:0]      idx_lat;
    logic [PC_W-1:0] pc_lat;
    logic [15:0]     sp_lat;

    logic [7:0]      req;
    logic            req_valid;
    logic [2:0]      req_idx;
    logic            accept;
    logic [15:0]     pc_ext;

    assign req = tifr & timsk;

    priority_encoder_8 u_prio (
        .req   (req),
        .valid (req_valid),
        .idx   (req_idx)
    );

    // guard masks the cycle right after VECTOR, while the SREG.I clear is
    // still propagating back to sreg_i.
    assign accept = (state == ST_IDLE) && instr_boundary && sreg_i && req_valid && !guard;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            guard   <= 1'b0;
            idx_lat <= 3'd0;
            pc_lat  <= '0;
            sp_lat  <= 16'h0000;
        end else begin
            guard <= (state == ST_VECTOR);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_PUSH_L;
                        idx_lat <= req_idx;
                        pc_lat  <= program_counter;
                        sp_lat  <= sp;
                    end
                end
                ST_PUSH_L: state <= ST_PUSH_H;
                ST_PUSH_H: state <= ST_VECTOR;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Return address zero-extended to 16 bits so the high push byte carries
    // zeros above the PC width.
    assign pc_ext = 16'(pc_lat);

    // Moore outputs decoded from state and the latched registers; data-path
    // outputs read zero outside the state that drives them.
    always_comb begin
        hold         = 1'b0;
        PC_overwrite = 1'b0;
        PC_new       = '0;
        mem_we       = 1'b0;
        mem_addr     = 16'h0000;
        mem_data     = 8'h00;
        sp_we        = 1'b0;
        sp_new       = 16'h0000;
        clear_i      = 1'b0;
        tifr_clear   = 8'h00;
        busy         = (state != ST_IDLE);
        case (state)
            ST_PUSH_L: begin
                hold     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = sp_lat;
                mem_data = pc_ext[7:0];
            end
            ST_PUSH_H: begin
                hold     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = sp_lat - 16'd1;
                mem_data = pc_ext[15:8];
            end
            ST_VECTOR: begin
                hold         = 1'b1;
                PC_overwrite = 1'b1;
                PC_new       = VEC_BASE + PC_W'(vec_offset(idx_lat));
                sp_we        = 1'b1;
                sp_new       = sp_lat - 16'd2;
                clear_i      = 1'b1;
                tifr_clear   = 8'h01 << idx_lat;
            end
            default: ;
        endcase
    end

endmodule
